// File: rtl/flag_hazard_ctrl_pkg.sv
// Purpose: shared condition-code encodings and NZVC flag struct for ALU, flag register and hazard control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: COND_* 4-bit ARM condition encodings, flags_t {n,z,v,c}, resolution FSM state type.
package flag_hazard_ctrl_pkg;

  localparam int COND_BITS = 4;

  localparam logic [COND_BITS-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_BITS-1:0] COND_NE = 4'b0001;
  localparam logic [COND_BITS-1:0] COND_CS = 4'b0010;
  localparam logic [COND_BITS-1:0] COND_CC = 4'b0011;
  localparam logic [COND_BITS-1:0] COND_MI = 4'b0100;
  localparam logic [COND_BITS-1:0] COND_PL = 4'b0101;
  localparam logic [COND_BITS-1:0] COND_VS = 4'b0110;
  localparam logic [COND_BITS-1:0] COND_VC = 4'b0111;
  localparam logic [COND_BITS-1:0] COND_HI = 4'b1000;
  localparam logic [COND_BITS-1:0] COND_LS = 4'b1001;
  localparam logic [COND_BITS-1:0] COND_GE = 4'b1010;
  localparam logic [COND_BITS-1:0] COND_LT = 4'b1011;
  localparam logic [COND_BITS-1:0] COND_GT = 4'b1100;
  localparam logic [COND_BITS-1:0] COND_LE = 4'b1101;
  localparam logic [COND_BITS-1:0] COND_AL = 4'b1110;
  localparam logic [COND_BITS-1:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } res_state_e;

endpackage

// File: rtl/flag_hazard_ctrl_if.sv
// Purpose: bundle of ID/EX control, ALU/stored flags and hazard-control results.
// Latency: n/a (wiring only).
// Backpressure: stall_in freezes ID/EX; stall_id asks the pipeline to hold ID.
// Modports: master = pipeline side (drives ID/EX/flags, sees results); slave = flag_hazard_ctrl.
interface flag_hazard_ctrl_if #(
  parameter int COND_W = 4
);
  logic              id_valid;
  logic              id_sets_flags;
  logic              id_is_bcond;
  logic [COND_W-1:0] id_cond;
  logic              stall_in;
  logic              flush_ex;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry_out;
  logic              negativeC;
  logic              zeroC;
  logic              overflowC;
  logic              carry_outC;
  logic              flag_en;
  logic              stall_id;
  logic              bcond_taken;
  logic              bcond_resolved;
  logic              ex_sets_flags;

  modport master (
    output id_valid, id_sets_flags, id_is_bcond, id_cond, stall_in, flush_ex,
    output alu_negative, alu_zero, alu_overflow, alu_carry_out,
    output negativeC, zeroC, overflowC, carry_outC,
    input  flag_en, stall_id, bcond_taken, bcond_resolved, ex_sets_flags
  );

  modport slave (
    input  id_valid, id_sets_flags, id_is_bcond, id_cond, stall_in, flush_ex,
    input  alu_negative, alu_zero, alu_overflow, alu_carry_out,
    input  negativeC, zeroC, overflowC, carry_outC,
    output flag_en, stall_id, bcond_taken, bcond_resolved, ex_sets_flags
  );

endinterface

// File: rtl/flag_hazard_ctrl_cond_eval.sv
// Purpose: evaluate an ARM condition code against NZVC flags.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: flags (flags_t) and cond in, taken out.
module cond_eval
  import flag_hazard_ctrl_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  flags_t            flags,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_CS: taken = flags.c;
      COND_CC: taken = ~flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = ~flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = ~flags.v;
      COND_HI: taken = flags.c & ~flags.z;
      COND_LS: taken = ~flags.c | flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = ~flags.z & (flags.n == flags.v);
      COND_LE: taken = flags.z | (flags.n != flags.v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Purpose: track the flag setter in EX, write the flag register once, forward/stall B.cond in ID.
// Latency: B.cond resolves combinationally in ID; flag write lands on the edge the setter leaves EX.
// Backpressure: stall_in freezes EX tracking and the resolve FSM; stall_id holds ID when not forwarding.
// Ports: clk, reset (sync, active-high), bus (flag_hazard_ctrl_if.slave).
module flag_hazard_ctrl
  import flag_hazard_ctrl_pkg::*;
#(
  parameter int FORWARD = 1,
  parameter int COND_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  flag_hazard_ctrl_if.slave  bus
);

  localparam logic FWD = (FORWARD != 0);

  logic       ex_sets_flags_q;
  res_state_e state;
  logic       bcond_in_id;
  logic       stall_id;
  logic       resolve;
  logic       cond_true;
  flags_t     alu_flags;
  flags_t     stored_flags;
  flags_t     eval_flags;

  assign alu_flags    = flags_t'({bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out});
  assign stored_flags = flags_t'({bus.negativeC, bus.zeroC, bus.overflowC, bus.carry_outC});

  assign bcond_in_id = bus.id_valid & bus.id_is_bcond;

  // Without forwarding, a B.cond behind a setter must wait for the stored flags.
  assign stall_id = bcond_in_id & ex_sets_flags_q & ~FWD;

  // When not forwarding, ex_sets_flags_q=1 always coincides with stall_id, so the
  // stored flags are only consumed once the setter has retired.
  assign eval_flags = (ex_sets_flags_q && FWD) ? alu_flags : stored_flags;

  cond_eval #(
    .COND_W (COND_W)
  ) u_cond_eval (
    .flags (eval_flags),
    .cond  (bus.id_cond),
    .taken (cond_true)
  );

  // Resolution only from IDLE: a B.cond frozen by stall_in was already resolved
  // and sits in HELD until ID advances. Masked by reset so outputs stay quiet.
  assign resolve = (state == ST_IDLE) & bcond_in_id & ~stall_id & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_sets_flags_q <= 1'b0;
      state           <= ST_IDLE;
    end else begin
      // stall_in has priority over both the bubble and flush.
      if (!bus.stall_in) begin
        if (stall_id || bus.flush_ex) begin
          ex_sets_flags_q <= 1'b0;
        end else begin
          ex_sets_flags_q <= bus.id_valid & bus.id_sets_flags;
        end
      end

      case (state)
        ST_IDLE: if (resolve && bus.stall_in) state <= ST_HELD;
        ST_HELD: if (!bus.stall_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A setter held in EX by stall_in must not rewrite; the write goes out on release.
  assign bus.flag_en        = ex_sets_flags_q & ~bus.stall_in;
  assign bus.stall_id       = stall_id;
  assign bus.bcond_resolved = resolve;
  assign bus.bcond_taken    = resolve & cond_true;
  assign bus.ex_sets_flags  = ex_sets_flags_q;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
module tb_flag_hazard_ctrl;
  import flag_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // bus_f drives the forwarding instance, bus_s the stalling instance.
  flag_hazard_ctrl_if #(.COND_W(4)) bus_f ();
  flag_hazard_ctrl_if #(.COND_W(4)) bus_s ();

  flag_hazard_ctrl #(.FORWARD(1), .COND_W(4)) u_fwd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  flag_hazard_ctrl #(.FORWARD(0), .COND_W(4)) u_stl (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic sf, input logic bc, input logic [3:0] cond);
    bus_f.id_valid = v;  bus_f.id_sets_flags = sf; bus_f.id_is_bcond = bc; bus_f.id_cond = cond;
    bus_s.id_valid = v;  bus_s.id_sets_flags = sf; bus_s.id_is_bcond = bc; bus_s.id_cond = cond;
  endtask

  task automatic set_ctl(input logic si, input logic fl);
    bus_f.stall_in = si; bus_f.flush_ex = fl;
    bus_s.stall_in = si; bus_s.flush_ex = fl;
  endtask

  // {n,z,v,c}
  task automatic set_alu(input logic [3:0] f);
    {bus_f.alu_negative, bus_f.alu_zero, bus_f.alu_overflow, bus_f.alu_carry_out} = f;
    {bus_s.alu_negative, bus_s.alu_zero, bus_s.alu_overflow, bus_s.alu_carry_out} = f;
  endtask

  task automatic set_st(input logic [3:0] f);
    {bus_f.negativeC, bus_f.zeroC, bus_f.overflowC, bus_f.carry_outC} = f;
    {bus_s.negativeC, bus_s.zeroC, bus_s.overflowC, bus_s.carry_outC} = f;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {flags n,z,v,c ; cond ; expected taken}
  logic [8:0] vecs [19];

  initial begin
    vecs = '{
      9'b0000_0000_0, 9'b0100_0000_1, 9'b0100_0001_0, 9'b0001_0010_1,
      9'b0001_0011_0, 9'b1000_0100_1, 9'b1000_0101_0, 9'b0010_0110_1,
      9'b0010_0111_0, 9'b0001_1000_1, 9'b0101_1000_0, 9'b0101_1001_1,
      9'b1010_1010_1, 9'b1000_1011_1, 9'b0000_1100_1, 9'b0100_1100_0,
      9'b0010_1101_1, 9'b0000_1101_0, 9'b0000_1111_1
    };

    reset = 1'b1;
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    set_ctl(1'b0, 1'b0);
    set_alu(4'b0000);
    set_st(4'b0000);
    tick();
    tick();

    // Outputs quiet while reset is held, even with a B.AL sitting in ID.
    set_id(1'b1, 1'b0, 1'b1, COND_AL);
    #2;
    chk("rst_resolved", bus_f.bcond_resolved, 1'b0);
    chk("rst_taken",    bus_f.bcond_taken,    1'b0);
    chk("rst_flag_en",  bus_f.flag_en,        1'b0);
    chk("rst_ex",       bus_f.ex_sets_flags,  1'b0);
    chk("rst_stall_id", bus_s.stall_id,       1'b0);
    tick();
    reset = 1'b0;
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    tick();

    // A: SUBS then B.EQ, forwarding ALU Z=1.
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    set_id(1'b1, 1'b0, 1'b1, COND_EQ);
    set_alu(4'b0100);
    set_st(4'b0000);
    #2;
    chk("a_resolved", bus_f.bcond_resolved, 1'b1);
    chk("a_taken",    bus_f.bcond_taken,    1'b1);
    chk("a_stall_id", bus_f.stall_id,       1'b0);
    chk("a_flag_en",  bus_f.flag_en,        1'b1);
    chk("a_ex",       bus_f.ex_sets_flags,  1'b1);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    #2;
    chk("a_flag_en_once", bus_f.flag_en, 1'b0);
    tick();

    // B: same sequence without forwarding: one stall cycle, then stored Z=1.
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    set_id(1'b1, 1'b0, 1'b1, COND_EQ);
    set_alu(4'b0100);
    set_st(4'b0000);
    #2;
    chk("b_stall_id", bus_s.stall_id,       1'b1);
    chk("b_no_res",   bus_s.bcond_resolved, 1'b0);
    chk("b_flag_en",  bus_s.flag_en,        1'b1);
    tick();
    set_st(4'b0100);
    #2;
    chk("b_stall_off", bus_s.stall_id,       1'b0);
    chk("b_bubble",    bus_s.ex_sets_flags,  1'b0);
    chk("b_resolved",  bus_s.bcond_resolved, 1'b1);
    chk("b_taken",     bus_s.bcond_taken,    1'b1);
    chk("b_no_rewr",   bus_s.flag_en,        1'b0);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    #2;
    chk("b_single", bus_s.bcond_resolved, 1'b0);
    tick();

    // C: setter held in EX for 3 stall cycles (flush asserted too: stall wins).
    set_alu(4'b0000);
    set_st(4'b0000);
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    set_ctl(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("c_hold_flag_en", bus_f.flag_en,       1'b0);
      chk("c_hold_ex",      bus_f.ex_sets_flags, 1'b1);
      tick();
    end
    set_ctl(1'b0, 1'b0);
    #2;
    chk("c_release",   bus_f.flag_en, 1'b1);
    chk("c_release_s", bus_s.flag_en, 1'b1);
    tick();
    #2;
    chk("c_after", bus_f.flag_en, 1'b0);
    tick();

    // D: B.GE with N=1,V=0 frozen for 2 cycles: one pulse, not taken.
    set_st(4'b1000);
    set_id(1'b1, 1'b0, 1'b1, COND_GE);
    set_ctl(1'b1, 1'b0);
    #2;
    chk("d_resolved",   bus_f.bcond_resolved, 1'b1);
    chk("d_taken",      bus_f.bcond_taken,    1'b0);
    chk("d_resolved_s", bus_s.bcond_resolved, 1'b1);
    tick();
    #2;
    chk("d_held", bus_f.bcond_resolved, 1'b0);
    tick();
    set_ctl(1'b0, 1'b0);
    #2;
    chk("d_release", bus_f.bcond_resolved, 1'b0);
    chk("d_release_tk", bus_f.bcond_taken, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 1'b1, COND_AL);
    #2;
    chk("d_next_res", bus_f.bcond_resolved, 1'b1);
    chk("d_next_tk",  bus_f.bcond_taken,    1'b1);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    tick();

    // E: flushed SUBS never becomes a setter; B.NE reads stored Z=1.
    set_st(4'b0100);
    set_alu(4'b0000);
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    set_ctl(1'b0, 1'b1);
    tick();
    set_ctl(1'b0, 1'b0);
    set_id(1'b1, 1'b0, 1'b1, COND_NE);
    #2;
    chk("e_ex",       bus_f.ex_sets_flags,  1'b0);
    chk("e_flag_en",  bus_f.flag_en,        1'b0);
    chk("e_stall_s",  bus_s.stall_id,       1'b0);
    chk("e_resolved", bus_f.bcond_resolved, 1'b1);
    chk("e_taken",    bus_f.bcond_taken,    1'b0);
    chk("e_taken_s",  bus_s.bcond_taken,    1'b0);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    tick();

    // G: back-to-back setters, one write each.
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    #2;
    chk("g_first", bus_f.flag_en, 1'b1);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    #2;
    chk("g_second", bus_f.flag_en, 1'b1);
    tick();
    #2;
    chk("g_done", bus_f.flag_en, 1'b0);
    tick();

    // H: condition table against stored flags.
    set_alu(4'b0000);
    for (int i = 0; i < 19; i++) begin
      set_st(vecs[i][8:5]);
      set_id(1'b1, 1'b0, 1'b1, vecs[i][4:1]);
      #2;
      chk($sformatf("h_cond%0d", i), bus_f.bcond_taken, vecs[i][0]);
      tick();
    end
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    tick();

    // F: reset while a setter is frozen in EX and a B.cond is HELD.
    set_st(4'b0000);
    set_id(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    set_id(1'b1, 1'b0, 1'b1, COND_AL);
    set_ctl(1'b1, 1'b0);
    #2;
    chk("f_resolved", bus_f.bcond_resolved, 1'b1);
    chk("f_no_write", bus_f.flag_en,        1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ctl(1'b0, 1'b0);
    #2;
    chk("f_flag_en", bus_f.flag_en,        1'b0);
    chk("f_ex",      bus_f.ex_sets_flags,  1'b0);
    chk("f_idle",    bus_f.bcond_resolved, 1'b1);
    tick();
    set_id(1'b0, 1'b0, 1'b0, 4'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flag_hazard_ctrl.md
Name: flag_hazard_ctrl

Overview:
- Sequences the NZVC condition-flag register in the 5-stage pipeline. Flags are produced in EX and conditional branches (B.cond) are resolved in ID.
- Tracks which EX-stage instruction sets flags, drives the flag-register write enable exactly once per flag-setting instruction, and forwards or stalls so that every B.cond sees the youngest older flags.
- Sits between the ID/EX pipeline control and the 4-bit flag register; the flag register itself is a separate instance.

Parameters:
FORWARD, 1, 1 = forward ALU flags from EX to a B.cond in ID; 0 = stall ID until the flag write retires.
COND_W, 4, condition-code field width (fixed ARM encoding).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
id_valid  input  1  ID holds a real instruction
id_sets_flags  input  1  ID instruction is ADDS/SUBS-class
id_is_bcond  input  1  ID instruction is B.cond
id_cond  input  COND_W  condition code of the B.cond
stall_in  input  1  global stall; freezes ID and EX
flush_ex  input  1  squash the instruction moving ID->EX
alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  EX ALU flags, this cycle
negativeC, zeroC, overflowC, carry_outC  input  1 each  stored flag-register outputs
flag_en  output  1  write enable to the flag register
stall_id  output  1  request to hold ID and inject an EX bubble
bcond_taken  output  1  condition true; valid only while bcond_resolved=1
bcond_resolved  output  1  one-cycle pulse per B.cond resolution
ex_sets_flags  output  1  EX holds a pending flag setter (debug/visibility)

Behaviour:
- Reset (synchronous): ex_sets_flags=0, FSM=IDLE. All outputs read 0 in the cycle after reset is sampled and for as long as reset is held.
- EX tracking register, updated each edge:
  - stall_in=1: hold.
  - else stall_id=1 or flush_ex=1: load 0 (bubble).
  - else: load id_valid & id_sets_flags.
- flag_en = ex_sets_flags & ~stall_in (combinational). The write therefore happens once, on the edge where the setter leaves EX. A held EX must not rewrite.
- Flag source for B.cond:
  - ex_sets_flags=1 and FORWARD=1: use the alu_* flags.
  - ex_sets_flags=0: use the stored *C flags.
- stall_id = id_valid & id_is_bcond & ex_sets_flags & (FORWARD==0). It stays high until the setter retires; the next cycle evaluates the stored flags.
- Condition evaluation (combinational):
  - EQ Z, NE !Z
  - CS C, CC !C
  - MI N, PL !N
  - VS V, VC !V
  - HI C&!Z, LS !C|Z
  - GE N==V, LT N!=V
  - GT !Z&(N==V), LE Z|(N!=V)
  - 1110/1111 always true.
- Resolution FSM, states IDLE and HELD:
  - IDLE: when id_valid & id_is_bcond & ~stall_id, pulse bcond_resolved=1 with bcond_taken. If stall_in=1 in that cycle, go to HELD.
  - HELD: bcond_resolved=0 and bcond_taken=0; return to IDLE on the first cycle with stall_in=0 (ID advances). A frozen B.cond is never resolved twice.
- flush_ex does not affect ID-side resolution; the upstream flush of ID is the pipeline's responsibility.
- Simultaneous events:
  - stall_in with flush_ex: stall wins (hold).
  - B.cond in ID whose own id_sets_flags=1: illegal, no defined requirement.
  - Back-to-back setters: each produces exactly one flag_en, in order.
- Reset mid-operation: a pending flag write is dropped (flag_en=0 next cycle) and a HELD B.cond is forgotten.

Decomposition:
- Shared package (cpu_pkg): cond-code localparams EQ..AL and the flag struct {n,z,v,c} used by the ALU, the flag register and this block.
- Sub-module cond_eval: purely combinational, {flags, cond} -> taken. It is reused by the branch unit.

Test Plan:
- SUBS (EX alu_zero=1) followed by B.EQ (0000) in ID, FORWARD=1 -> same cycle bcond_resolved=1, bcond_taken=1, stall_id=0; flag_en=1 for exactly one cycle.
- Same sequence, FORWARD=0 -> stall_id=1 for 1 cycle, EX bubble, then resolved with stored zeroC=1, taken=1.
- Setter in EX, stall_in held 3 cycles -> flag_en=0 during the stall, flag_en=1 on the release cycle only.
- B.GE (1010) with N=1,V=0 and stall_in high for 2 cycles -> one bcond_resolved pulse, taken=0; no second pulse after release.
- flush_ex on a SUBS entering EX -> ex_sets_flags stays 0, no flag_en, and a following B.NE uses the stored flags.
- reset asserted while a setter is in EX and stall_in=1 -> next cycle flag_en=0, ex_sets_flags=0, FSM IDLE.
